// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the fetch/data memory arbiter
package defs;

  localparam int DEF_BIN_DIG       = 32;
  localparam int DEF_MAX_DM_STREAK = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } mem_arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter between fetch and data ports onto one memory port
module mem_arbiter
  import defs::*;
#(
  parameter int BIN_DIG       = DEF_BIN_DIG,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               if_req,
  input  logic [BIN_DIG-1:0] if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [BIN_DIG-1:0] if_rdata,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [3:0]         dm_be,
  input  logic [BIN_DIG-1:0] dm_addr,
  input  logic [BIN_DIG-1:0] dm_wdata,
  output logic               dm_gnt,
  output logic               dm_rvalid,
  output logic [BIN_DIG-1:0] dm_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [3:0]         mem_be,
  output logic [BIN_DIG-1:0] mem_addr,
  output logic [BIN_DIG-1:0] mem_wdata,
  input  logic               mem_ack,
  input  logic [BIN_DIG-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  mem_arb_state_t state;
  logic [SW-1:0]  streak;
  logic           idle;
  logic           streak_full;
  logic           dm_win;
  logic           if_win;

  // Data normally wins; a full streak of contested data grants hands one slot to fetch.
  assign idle        = (state == IDLE) && RST;
  assign streak_full = (streak == SW'(MAX_DM_STREAK));
  assign dm_win      = dm_req && !(if_req && streak_full);
  assign if_win      = if_req && !dm_win;
  assign dm_gnt      = idle && dm_win;
  assign if_gnt      = idle && if_win;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dm_gnt) begin
            state     <= BUSY_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_be;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_req && !streak_full) begin
              streak <= streak + SW'(1);
            end
          end else if (if_gnt) begin
            state     <= BUSY_IF;
            streak    <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'hF;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          // Request fields stay frozen; only the ack releases the port.
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == BUSY_IF) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end else begin
              dm_rvalid <= 1'b1;
              dm_rdata  <= mem_we ? '0 : mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        rsp_ack, man_ack, resp_en;
  logic [31:0] rsp_rdata, man_rdata;
  int          lat;
  int          cnt;

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fails  = 0;

  assign mem_ack   = rsp_ack | man_ack;
  assign mem_rdata = man_ack ? man_rdata : rsp_rdata;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic is_dm, input logic [31:0] data);
    exp_t e;
    e.is_dm = is_dm;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick;
    check_eq(tag, sb.size(), 0);
  endtask

  // Memory responder: ack lat cycles after mem_req is first seen.
  initial begin
    rsp_ack = 1'b0; rsp_rdata = '0; cnt = 0;
    forever begin
      @(posedge CLK); #1;
      rsp_ack = 1'b0;
      if (resp_en && mem_req === 1'b1) begin
        if (cnt == lat) begin
          rsp_ack   = 1'b1;
          rsp_rdata = mem_model(mem_addr);
          cnt       = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  logic        pv_req, pv_ack;
  logic [68:0] pv_fields;

  // Completion monitor and port-stability watch.
  initial begin
    exp_t e;
    pv_req = 1'b0; pv_ack = 1'b0; pv_fields = '0;
    forever begin
      @(posedge CLK); #3;
      if (if_gnt === 1'b1 || dm_gnt === 1'b1) check_eq("gnt_excl", {31'b0, if_gnt & dm_gnt}, 32'h0);
      if (if_rvalid === 1'b1 || dm_rvalid === 1'b1) begin
        check_eq("rvalid_excl", {31'b0, if_rvalid & dm_rvalid}, 32'h0);
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_rvalid", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          check_eq("sb_src", {31'b0, dm_rvalid}, {31'b0, e.is_dm});
          check_eq("sb_data", dm_rvalid ? dm_rdata : if_rdata, e.data);
        end
      end
      if (pv_req === 1'b1 && mem_req === 1'b1 && pv_ack === 1'b0) begin
        check_eq("stable_addr", mem_addr, pv_fields[63:32]);
        check_eq("stable_ctl", {27'b0, mem_we, mem_be}, {27'b0, pv_fields[68:64]});
        check_eq("stable_wdata", mem_wdata, pv_fields[31:0]);
      end
      pv_req    = mem_req;
      pv_ack    = mem_ack;
      pv_fields = {mem_we, mem_be, mem_addr, mem_wdata};
    end
  end

  logic exp_src [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int g, di, ii;
    logic found, lastd, lasti;
    RST = 1'b0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_be = 4'hF;
    dm_addr = '0; dm_wdata = '0; man_ack = 0; man_rdata = '0; resp_en = 1'b1; lat = 1;

    // Reset state and gnt suppression while in reset
    tick; tick;
    if_req = 1; dm_req = 1;
    #1;
    check_eq("rst_if_gnt", {31'b0, if_gnt}, 0);
    check_eq("rst_dm_gnt", {31'b0, dm_gnt}, 0);
    tick; #1;
    check_eq("rst_mem_req", {31'b0, mem_req}, 0);
    check_eq("rst_mem_ctl", {27'b0, mem_we, mem_be}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_rvalid", {30'b0, if_rvalid, dm_rvalid}, 0);
    check_eq("rst_rdata", if_rdata | dm_rdata, 0);
    tick;
    if_req = 0; dm_req = 0; RST = 1'b1;
    tick;

    // Fetch only, ack one cycle after mem_req
    tick;
    if_req = 1; if_addr = 32'h100; lat = 1; push(0, 32'h13);
    #1;
    check_eq("f_if_gnt", {31'b0, if_gnt}, 1);
    check_eq("f_dm_gnt", {31'b0, dm_gnt}, 0);
    tick; if_req = 0; #1;
    check_eq("f_mem_req", {31'b0, mem_req}, 1);
    check_eq("f_mem_addr", mem_addr, 32'h100);
    check_eq("f_mem_ctl", {27'b0, mem_we, mem_be}, 32'hF);
    check_eq("f_mem_wdata", mem_wdata, 0);
    tick; #1;
    check_eq("f_no_early_rvalid", {31'b0, if_rvalid}, 0);
    tick; #1;
    check_eq("f_rvalid", {31'b0, if_rvalid}, 1);
    check_eq("f_rdata", if_rdata, 32'h13);
    tick; #1;
    check_eq("f_rvalid_pulse", {31'b0, if_rvalid}, 0);
    check_eq("f_rdata_hold", if_rdata, 32'h13);

    // Simultaneous requests: data first, fetch in the IDLE cycle after the data ack
    tick;
    if_req = 1; if_addr = 32'h104; dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h2000; lat = 1;
    push(1, mem_model(32'h2000)); push(0, mem_model(32'h104));
    #1;
    check_eq("c_dm_gnt", {31'b0, dm_gnt}, 1);
    check_eq("c_if_gnt", {31'b0, if_gnt}, 0);
    tick; dm_req = 0; #1;
    check_eq("c_busy_no_gnt", {31'b0, if_gnt}, 0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick; #1;
      if (if_gnt) begin
        found = 1;
        check_eq("c_ifgnt_with_dm_rvalid", {31'b0, dm_rvalid}, 1);
        break;
      end
    end
    check_eq("c_if_gnt_seen", {31'b0, found}, 1);
    tick; if_req = 0;
    drain("c_drain");

    // Starvation: continuous contested requests, single-cycle ack
    di = 0; ii = 0;
    for (int k = 0; k < 10; k++) begin
      if (exp_src[k]) begin push(1, mem_model(32'h4000 + 4 * di)); di++; end
      else begin push(0, mem_model(32'h200 + 4 * ii)); ii++; end
    end
    tick;
    lat = 0; if_req = 1; if_addr = 32'h200; dm_req = 1; dm_we = 0; dm_addr = 32'h4000;
    g = 0;
    for (int c = 0; c < 100 && g < 10; c++) begin
      #1;
      lastd = dm_gnt; lasti = if_gnt;
      if (dm_gnt || if_gnt) begin
        check_eq($sformatf("s_order_%0d", g), {31'b0, dm_gnt}, {31'b0, exp_src[g]});
        g++;
      end
      tick;
      if (lastd) dm_addr += 4;
      if (lasti) if_addr += 4;
      if (g == 10) begin if_req = 0; dm_req = 0; end
    end
    check_eq("s_grant_count", g, 10);
    if_req = 0; dm_req = 0;
    drain("s_drain");

    // Data write: registered fields held until ack, completion carries zero data
    tick;
    dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h3000; dm_wdata = 32'hDEADBEEF; lat = 2;
    push(1, 32'h0);
    #1;
    check_eq("w_dm_gnt", {31'b0, dm_gnt}, 1);
    tick;
    dm_req = 0; dm_we = 0; dm_be = 4'hF; dm_addr = '0; dm_wdata = '0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_req) begin
        check_eq("w_mem_ctl", {27'b0, mem_we, mem_be}, {27'b0, 1'b1, 4'b0011});
        check_eq("w_mem_addr", mem_addr, 32'h3000);
        check_eq("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
      end
      if (dm_rvalid) begin
        found = 1;
        check_eq("w_dm_rdata", dm_rdata, 0);
        break;
      end
      tick;
    end
    check_eq("w_rvalid_seen", {31'b0, found}, 1);
    tick; #1;
    check_eq("w_rvalid_pulse", {31'b0, dm_rvalid}, 0);

    // Reset while BUSY_DM, late ack after release
    tick;
    resp_en = 0; dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h5000;
    #1;
    check_eq("r_dm_gnt", {31'b0, dm_gnt}, 1);
    tick; dm_req = 0; #1;
    check_eq("r_mem_req_busy", {31'b0, mem_req}, 1);
    tick; RST = 0; dm_req = 1;
    tick; #1;
    check_eq("r_mem_req_cleared", {31'b0, mem_req}, 0);
    check_eq("r_gnt_held_low", {31'b0, dm_gnt}, 0);
    tick; RST = 1; dm_req = 0;
    tick; man_ack = 1; man_rdata = 32'hBAD0BAD0; #1;
    check_eq("r_mem_req_idle", {31'b0, mem_req}, 0);
    tick; man_ack = 0; #1;
    check_eq("r_no_rvalid", {30'b0, if_rvalid, dm_rvalid}, 0);
    tick; #1;
    check_eq("r_still_idle", {31'b0, mem_req}, 0);
    tick;
    resp_en = 1; lat = 0; if_req = 1; if_addr = 32'h600; push(0, mem_model(32'h600));
    #1;
    check_eq("r_served_after", {31'b0, if_gnt}, 1);
    tick; if_req = 0;
    drain("r_drain");

    // Spurious ack in IDLE
    tick;
    resp_en = 0; man_ack = 1; man_rdata = 32'h1234;
    tick; man_ack = 0; #1;
    check_eq("sp_no_rvalid", {30'b0, if_rvalid, dm_rvalid}, 0);
    check_eq("sp_no_req", {31'b0, mem_req}, 0);
    tick;
    resp_en = 1; lat = 1; dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h7000;
    push(1, mem_model(32'h7000));
    #1;
    check_eq("sp_dm_gnt", {31'b0, dm_gnt}, 1);
    tick; dm_req = 0;
    drain("sp_drain");

    tick; tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
